onewire_temp_slave: RTL and testbench
=====================================

Name: onewire_temp_slave

Overview:
- 1-Wire responder that emulates a single DS18B20-style temperature sensor on the shared 1-Wire pin.
- Lets the team's 1-Wire temperature master be exercised on-chip or in loopback without a real sensor.
- Detects reset pulses, answers with a presence pulse, and decodes Skip ROM, Convert T and Read Scratchpad.
- Returns a 9-byte scratchpad built from a parallel temperature input, with CRC8 generated on the fly.

Parameters:
- CLK_HZ, 24000000, system clock frequency; all timing constants derive from it.
- RST_MIN_US, 400, minimum line-low time recognised as a bus reset.
- PRES_WAIT_US, 30, delay from reset-pulse release to presence start.
- PRES_LEN_US, 120, presence pulse length.
- SAMPLE_US, 30, offset after a slot's falling edge at which write bits are sampled and read-0 drive ends.

Ports:
- i_clk, input, 1, system clock.
- i_rst_n, input, 1, asynchronous active-low reset.
- i_owr, input, 1, raw 1-Wire line level from the pad (asynchronous).
- o_owr, output, 1, 1 = pull line low (drives pad OE; pad data is 0); 0 = release.
- i_temp, input, 16, signed temperature in DS18B20 format (1/16 °C LSB).
- o_conv_req, output, 1, one-cycle pulse when Convert T is received.
- o_cmd_valid, output, 1, one-cycle pulse per received command byte.
- o_cmd, output, 8, last received command byte.

Behaviour:
- Reset (i_rst_n=0) values: o_owr=0, o_conv_req=0, o_cmd_valid=0, o_cmd=0x00, state IDLE, temperature latch=0x0550 (+85 °C).
- Input synchroniser: i_owr passes through 2 flops. Falling and rising edges are detected on the synchronised signal, giving 2–3 cycles input latency.
- Low-time counter: counts while the synchronised line is low, saturating.
- Bus reset: on any rising edge with low-time >= RST_MIN cycles, jump to PRES_WAIT from any state. In-progress byte, bit counters and CRC are discarded. This takes priority over every other event on the same cycle.
- States:
  - IDLE: ignore slots; wait for a bus reset.
  - PRES_WAIT: wait PRES_WAIT cycles, then go to PRESENCE.
  - PRESENCE: o_owr=1 for PRES_LEN cycles, then release and go to ROM_CMD.
  - ROM_CMD: receive 8 bits. 0xCC goes to FUNC_CMD. Any other value goes to IDLE.
  - FUNC_CMD: receive 8 bits.
    - 0x44: pulse o_conv_req, latch i_temp, go to CONV.
    - 0xBE: go to TX_SCRATCH with byte index 0 and CRC=0.
    - Any other value: go to IDLE.
  - CONV: each read slot returns 1 (conversion complete, immediately).
  - TX_SCRATCH: transmits bytes LSB first in this order: temp[7:0], temp[15:8], 0x4B, 0x46, 0x7F, 0xFF, 0x0C, 0x10, CRC. After the 72nd bit, further read slots return 1 (line released) and the state is held.
- Write slot (receive states): on a falling edge, start the slot counter. At SAMPLE cycles, sample the line: low = 0, high = 1. Bits shift in LSB first.
- On the 8th bit: o_cmd is updated and o_cmd_valid pulses on the same cycle the state transition is decided.
- A falling edge that arrives before the current slot has sampled restarts the slot.
- Read slot (TX states): on a falling edge, if the current bit is 0, assert o_owr until SAMPLE cycles from the edge, then release. If the bit is 1, never drive. Bit and byte counters advance at slot end, SAMPLE cycles after the edge.
- CRC8: polynomial x^8+x^5+x^4+1, reflected, init 0x00. It is updated per transmitted bit over bytes 0–7, so the 9th byte makes the total CRC 0.
- Timing constants are computed as CLK_HZ/1e6 × µs, rounded down. Counter width is sized to hold RST_MIN plus margin (≥16 bits at 24 MHz).
- o_owr is never asserted in IDLE, ROM_CMD or FUNC_CMD.

Test Plan:
- Bus reset: drive line low 480 µs (11520 cycles), then release. Expect o_owr rising about 30 µs (720 cycles) later, held for 2880 cycles. A 300 µs low pulse produces no presence.
- Skip ROM + Convert T: after presence, write 0xCC then 0x44 using 6 µs low for a 1 and 60 µs low for a 0. Expect o_cmd_valid twice (o_cmd=0xCC, then 0x44), one o_conv_req pulse, and read slots returning 1.
- Read scratchpad: set i_temp=0x0191 (+25.0625 °C), send 0xCC, 0x44, reset, 0xCC, 0xBE, then 72 read slots. Expect bytes 91 01 4B 46 7F FF 0C 10 followed by a CRC byte such that the CRC8 over all 9 bytes = 0. The line is held low for 30 µs on each 0 bit.
- Unknown command: send 0x33 as the ROM command. Expect o_cmd_valid with o_cmd=0x33, the state goes to IDLE, and o_owr stays 0 through the following 16 slots until the next reset.
- Reset mid-transfer: after 20 scratchpad bits, issue a 480 µs reset. Expect a fresh presence pulse, and a subsequent 0xCC/0xBE read restarting at byte 0 with the same data.
- Async reset: pull i_rst_n low mid-presence. o_owr must drop to 0 combinationally-free on the next evaluation (async clear), and the latch must read back 0x0550.

Source files
------------

// File: rtl/onewire_temp_slave.sv
// 1-Wire responder that looks like a single DS18B20 to the bus master.
// Supports Skip ROM, Convert T and Read Scratchpad. The CRC byte is built while the scratchpad shifts out.
module onewire_temp_slave #(
  parameter int unsigned CLK_HZ       = 24_000_000,
  parameter int unsigned RST_MIN_US   = 400,
  parameter int unsigned PRES_WAIT_US = 30,
  parameter int unsigned PRES_LEN_US  = 120,
  parameter int unsigned SAMPLE_US    = 30
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_owr,
  output logic        o_owr,
  input  logic [15:0] i_temp,
  output logic        o_conv_req,
  output logic        o_cmd_valid,
  output logic [7:0]  o_cmd
);

  localparam int unsigned CYC_US      = CLK_HZ / 1_000_000;
  localparam int unsigned RST_MIN_C   = CYC_US * RST_MIN_US;
  localparam int unsigned PRES_WAIT_C = CYC_US * PRES_WAIT_US;
  localparam int unsigned PRES_LEN_C  = CYC_US * PRES_LEN_US;
  localparam int unsigned SAMPLE_C    = CYC_US * SAMPLE_US;
  localparam int unsigned CW_RAW      = $clog2(RST_MIN_C + 1) + 2;
  localparam int unsigned CW          = (CW_RAW > 16) ? CW_RAW : 16;

  typedef logic [CW-1:0] cnt_t;

  localparam cnt_t RST_MIN   = cnt_t'(RST_MIN_C);
  localparam cnt_t PRES_WAIT = cnt_t'(PRES_WAIT_C);
  localparam cnt_t PRES_LEN  = cnt_t'(PRES_LEN_C);
  localparam cnt_t SAMPLE    = cnt_t'(SAMPLE_C);
  localparam cnt_t CNT_MAX   = '1;

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_PRES_WAIT = 3'd1;
  localparam logic [2:0] S_PRESENCE  = 3'd2;
  localparam logic [2:0] S_ROM_CMD   = 3'd3;
  localparam logic [2:0] S_FUNC_CMD  = 3'd4;
  localparam logic [2:0] S_CONV      = 3'd5;
  localparam logic [2:0] S_TX        = 3'd6;

  logic        sync1_q, sync2_q, prev_q;
  cnt_t        low_cnt_q, low_cnt_d;
  logic [2:0]  state_q, state_d;
  cnt_t        tmr_q, tmr_d;
  logic        slot_act_q, slot_act_d;
  cnt_t        slot_cnt_q, slot_cnt_d;
  logic [2:0]  bit_q, bit_d;
  logic [3:0]  byte_q, byte_d;
  logic [7:0]  rx_q, rx_d;
  logic [7:0]  crc_q, crc_d;
  logic        drive_q, drive_d;
  logic [7:0]  cmd_q, cmd_d;
  logic        cmd_vld_q, cmd_vld_d;
  logic        conv_q, conv_d;
  logic [15:0] temp_q, temp_d;

  logic       fall, rise, bus_rst, slot_end;
  logic [7:0] rx_byte, tx_byte, crc_nxt;
  logic       tx_bit, tx_done, crc_fb;

  assign fall     = prev_q & ~sync2_q;
  assign rise     = ~prev_q & sync2_q;
  assign bus_rst  = rise && (low_cnt_q >= RST_MIN);
  assign slot_end = slot_act_q && (slot_cnt_q == SAMPLE - cnt_t'(1));
  assign rx_byte  = {sync2_q, rx_q[7:1]};

  always_comb begin
    case (byte_q)
      4'd0:    tx_byte = temp_q[7:0];
      4'd1:    tx_byte = temp_q[15:8];
      4'd2:    tx_byte = 8'h4B;
      4'd3:    tx_byte = 8'h46;
      4'd4:    tx_byte = 8'h7F;
      4'd5:    tx_byte = 8'hFF;
      4'd6:    tx_byte = 8'h0C;
      4'd7:    tx_byte = 8'h10;
      default: tx_byte = crc_q;
    endcase
  end

  assign tx_bit  = tx_byte[bit_q];
  assign tx_done = (byte_q == 4'd9);
  // Reflected x^8+x^5+x^4+1; crc_q is frozen while byte 8 shifts out.
  assign crc_fb  = crc_q[0] ^ tx_bit;
  assign crc_nxt = {1'b0, crc_q[7:1]} ^ (crc_fb ? 8'h8C : 8'h00);

  always_comb begin
    state_d    = state_q;
    tmr_d      = tmr_q;
    slot_act_d = slot_act_q;
    slot_cnt_d = slot_cnt_q;
    bit_d      = bit_q;
    byte_d     = byte_q;
    rx_d       = rx_q;
    crc_d      = crc_q;
    drive_d    = drive_q;
    cmd_d      = cmd_q;
    cmd_vld_d  = 1'b0;
    conv_d     = 1'b0;
    temp_d     = temp_q;
    low_cnt_d  = sync2_q ? '0 :
                 (low_cnt_q == CNT_MAX) ? low_cnt_q : low_cnt_q + cnt_t'(1);

    if (bus_rst) begin
      state_d    = S_PRES_WAIT;
      tmr_d      = '0;
      slot_act_d = 1'b0;
      slot_cnt_d = '0;
      bit_d      = '0;
      byte_d     = '0;
      rx_d       = '0;
      crc_d      = '0;
      drive_d    = 1'b0;
    end else begin
      case (state_q)
        S_PRES_WAIT: begin
          tmr_d = tmr_q + cnt_t'(1);
          if (tmr_q == PRES_WAIT - cnt_t'(1)) begin
            state_d = S_PRESENCE;
            tmr_d   = '0;
            drive_d = 1'b1;
          end
        end
        S_PRESENCE: begin
          tmr_d = tmr_q + cnt_t'(1);
          if (tmr_q == PRES_LEN - cnt_t'(1)) begin
            state_d    = S_ROM_CMD;
            drive_d    = 1'b0;
            slot_act_d = 1'b0;
            bit_d      = '0;
          end
        end
        S_ROM_CMD, S_FUNC_CMD: begin
          // A new falling edge before sampling simply restarts the slot.
          if (fall) begin
            slot_act_d = 1'b1;
            slot_cnt_d = '0;
          end else if (slot_end) begin
            slot_act_d = 1'b0;
            rx_d       = rx_byte;
            bit_d      = bit_q + 3'd1;
            if (bit_q == 3'd7) begin
              cmd_d     = rx_byte;
              cmd_vld_d = 1'b1;
              if (state_q == S_ROM_CMD) begin
                state_d = (rx_byte == 8'hCC) ? S_FUNC_CMD : S_IDLE;
              end else begin
                case (rx_byte)
                  8'h44: begin
                    conv_d  = 1'b1;
                    temp_d  = i_temp;
                    state_d = S_CONV;
                  end
                  8'hBE: begin
                    state_d = S_TX;
                    byte_d  = '0;
                    crc_d   = '0;
                  end
                  default: state_d = S_IDLE;
                endcase
              end
            end
          end else if (slot_act_q) begin
            slot_cnt_d = slot_cnt_q + cnt_t'(1);
          end
        end
        S_CONV, S_TX: begin
          // CONV always reads as 1 (conversion done), so it never drives.
          if (fall) begin
            slot_act_d = 1'b1;
            slot_cnt_d = '0;
            drive_d    = (state_q == S_TX) && !tx_done && !tx_bit;
          end else if (slot_end) begin
            slot_act_d = 1'b0;
            drive_d    = 1'b0;
            if (state_q == S_TX && !tx_done) begin
              if (byte_q < 4'd8) crc_d = crc_nxt;
              bit_d = bit_q + 3'd1;
              if (bit_q == 3'd7) byte_d = byte_q + 4'd1;
            end
          end else if (slot_act_q) begin
            slot_cnt_d = slot_cnt_q + cnt_t'(1);
          end
        end
        default: begin
          slot_act_d = 1'b0;
          drive_d    = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync1_q    <= 1'b1;
      sync2_q    <= 1'b1;
      prev_q     <= 1'b1;
      low_cnt_q  <= '0;
      state_q    <= S_IDLE;
      tmr_q      <= '0;
      slot_act_q <= 1'b0;
      slot_cnt_q <= '0;
      bit_q      <= '0;
      byte_q     <= '0;
      rx_q       <= '0;
      crc_q      <= '0;
      drive_q    <= 1'b0;
      cmd_q      <= '0;
      cmd_vld_q  <= 1'b0;
      conv_q     <= 1'b0;
      temp_q     <= 16'h0550;
    end else begin
      sync1_q    <= i_owr;
      sync2_q    <= sync1_q;
      prev_q     <= sync2_q;
      low_cnt_q  <= low_cnt_d;
      state_q    <= state_d;
      tmr_q      <= tmr_d;
      slot_act_q <= slot_act_d;
      slot_cnt_q <= slot_cnt_d;
      bit_q      <= bit_d;
      byte_q     <= byte_d;
      rx_q       <= rx_d;
      crc_q      <= crc_d;
      drive_q    <= drive_d;
      cmd_q      <= cmd_d;
      cmd_vld_q  <= cmd_vld_d;
      conv_q     <= conv_d;
      temp_q     <= temp_d;
    end
  end

  assign o_owr       = drive_q;
  assign o_conv_req  = conv_q;
  assign o_cmd_valid = cmd_vld_q;
  assign o_cmd       = cmd_q;

endmodule

// File: tb/tb_onewire_temp_slave.sv
// Loopback bench: a behavioural 1-Wire master on a wired-AND line against the responder.
// Runs at 1 MHz so one cycle is one microsecond.
`timescale 1ns/1ps
module tb_onewire_temp_slave;

  localparam int unsigned CLK_HZ = 1_000_000;
  localparam int PW   = 30;
  localparam int PL   = 120;
  localparam int SAMP = 30;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        m_low = 1'b0;
  logic [15:0] temp = 16'h1234;
  logic        o_owr, o_conv_req, o_cmd_valid;
  logic [7:0]  o_cmd;
  logic        line;

  assign line = ~(m_low | o_owr);

  onewire_temp_slave #(.CLK_HZ(CLK_HZ)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_owr(line), .o_owr(o_owr),
    .i_temp(temp), .o_conv_req(o_conv_req), .o_cmd_valid(o_cmd_valid), .o_cmd(o_cmd)
  );

  always #500 clk = ~clk;

  int         n_vec = 0;
  int         n_err = 0;
  logic [7:0] cmd_log[$];
  int         conv_cnt = 0;
  int         owr_hi = 0;

  always @(negedge clk) begin
    if (o_cmd_valid) cmd_log.push_back(o_cmd);
    if (o_conv_req) conv_cnt++;
    if (o_owr) owr_hi++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: DS18B20 CRC8 (Dallas/Maxim) over a byte list.
  function automatic logic [7:0] crc8(input logic [7:0] q[$]);
    logic [7:0] c = 8'h00;
    foreach (q[k]) begin
      logic [7:0] b = q[k];
      for (int j = 0; j < 8; j++) begin
        logic mix = c[0] ^ b[0];
        c = c >> 1;
        if (mix) c = c ^ 8'h8C;
        b = b >> 1;
      end
    end
    return c;
  endfunction

  function automatic logic [71:0] exp_scratch(input logic [15:0] t);
    logic [7:0]  q[$];
    logic [71:0] v;
    q = {t[7:0], t[15:8], 8'h4B, 8'h46, 8'h7F, 8'hFF, 8'h0C, 8'h10};
    q.push_back(crc8(q));
    for (int k = 0; k < 9; k++) v[k*8 +: 8] = q[k];
    return v;
  endfunction

  task automatic bus_reset(input int low_us, input bit exp_pres, input string tag);
    int t_rise = -1;
    int t_len = 0;
    m_low = 1'b1;
    repeat (low_us) tick();
    m_low = 1'b0;
    for (int i = 0; i < PW + PL + 40; i++) begin
      @(negedge clk);
      if (o_owr) begin
        if (t_rise < 0) t_rise = i;
        t_len++;
      end
      tick();
    end
    if (exp_pres) begin
      chk({tag, "_pres_dly_ok"}, 32'(t_rise >= PW && t_rise <= PW + 5), 32'd1);
      chk({tag, "_pres_len"}, 32'(t_len), 32'(PL));
    end else begin
      chk({tag, "_no_pres"}, 32'(t_len), 32'd0);
    end
  endtask

  task automatic write_byte(input logic [7:0] v);
    for (int k = 0; k < 8; k++) begin
      for (int i = 0; i < 70; i++) begin
        m_low = v[k] ? (i < 6) : (i < 60);
        tick();
      end
      m_low = 1'b0;
    end
  endtask

  // Read n slots, LSB first; also records the shortest/longest line-low time of 0 bits.
  task automatic read_bits(input int n, output logic [71:0] d, output int lo_min, output int lo_max);
    d = '0;
    lo_min = 1000;
    lo_max = 0;
    for (int k = 0; k < n; k++) begin
      int  low = 0;
      logic b = 1'b1;
      for (int i = 0; i < 70; i++) begin
        m_low = (i < 5);
        @(negedge clk);
        if (!line) low++;
        if (i == 15) b = line;
        tick();
      end
      m_low = 1'b0;
      d[k] = b;
      if (!b) begin
        if (low < lo_min) lo_min = low;
        if (low > lo_max) lo_max = low;
      end
    end
  endtask

  task automatic read_scratch_chk(input logic [15:0] t, input string tag);
    logic [71:0] d, e;
    logic [7:0]  q[$];
    int          lmin, lmax;
    bus_reset(480, 1'b1, tag);
    write_byte(8'hCC);
    write_byte(8'hBE);
    read_bits(72, d, lmin, lmax);
    e = exp_scratch(t);
    for (int k = 0; k < 9; k++) begin
      chk($sformatf("%s_byte%0d", tag, k), 32'(d[k*8 +: 8]), 32'(e[k*8 +: 8]));
      q.push_back(d[k*8 +: 8]);
    end
    chk({tag, "_crc_total"}, 32'(crc8(q)), 32'd0);
    chk({tag, "_zero_low_ok"}, 32'(lmin >= SAMP && lmax <= SAMP + 6), 32'd1);
    read_bits(4, d, lmin, lmax);
    chk({tag, "_after72"}, 32'(d[3:0]), 32'hF);
  endtask

  task automatic convert(input string tag);
    logic [71:0] d;
    int          lmin, lmax;
    bus_reset(480, 1'b1, tag);
    cmd_log.delete();
    conv_cnt = 0;
    write_byte(8'hCC);
    write_byte(8'h44);
    chk({tag, "_ncmd"}, 32'(cmd_log.size()), 32'd2);
    if (cmd_log.size() == 2) begin
      chk({tag, "_cmd0"}, 32'(cmd_log[0]), 32'hCC);
      chk({tag, "_cmd1"}, 32'(cmd_log[1]), 32'h44);
    end
    chk({tag, "_conv"}, 32'(conv_cnt), 32'd1);
    read_bits(2, d, lmin, lmax);
    chk({tag, "_done_bits"}, 32'(d[1:0]), 32'h3);
  endtask

  initial begin
    logic [71:0] d, e;
    logic [15:0] t_r;
    logic [7:0]  v;
    int          lmin, lmax, n_wait;

    repeat (5) tick();
    chk("rst_owr", 32'(o_owr), 32'd0);
    chk("rst_conv", 32'(o_conv_req), 32'd0);
    chk("rst_vld", 32'(o_cmd_valid), 32'd0);
    chk("rst_cmd", 32'(o_cmd), 32'd0);
    rst_n = 1'b1;
    repeat (3) tick();

    read_scratch_chk(16'h0550, "por");
    bus_reset(300, 1'b0, "short");

    temp = 16'h0191;
    convert("cv1");
    read_scratch_chk(16'h0191, "rd1");

    t_r  = 16'($urandom);
    temp = t_r;
    convert("cv2");
    temp = ~t_r;
    read_scratch_chk(t_r, "rd2");

    bus_reset(480, 1'b1, "urom");
    cmd_log.delete();
    write_byte(8'h33);
    chk("urom_ncmd", 32'(cmd_log.size()), 32'd1);
    if (cmd_log.size() == 1) chk("urom_cmd", 32'(cmd_log[0]), 32'h33);
    owr_hi = 0;
    read_bits(16, d, lmin, lmax);
    chk("urom_bits", 32'(d[15:0]), 32'hFFFF);
    chk("urom_owr", 32'(owr_hi), 32'd0);

    bus_reset(480, 1'b1, "ufn");
    v = 8'($urandom);
    if (v == 8'h44 || v == 8'hBE) v = 8'h55;
    cmd_log.delete();
    conv_cnt = 0;
    owr_hi = 0;
    write_byte(8'hCC);
    write_byte(v);
    chk("ufn_ncmd", 32'(cmd_log.size()), 32'd2);
    if (cmd_log.size() == 2) chk("ufn_cmd", 32'(cmd_log[1]), 32'(v));
    read_bits(16, d, lmin, lmax);
    chk("ufn_bits", 32'(d[15:0]), 32'hFFFF);
    chk("ufn_owr", 32'(owr_hi), 32'd0);
    chk("ufn_conv", 32'(conv_cnt), 32'd0);

    bus_reset(480, 1'b1, "mid");
    write_byte(8'hCC);
    write_byte(8'hBE);
    read_bits(20, d, lmin, lmax);
    e = exp_scratch(t_r);
    chk("mid_20bits", 32'(d[19:0]), 32'(e[19:0]));
    read_scratch_chk(t_r, "mid2");

    m_low = 1'b1;
    repeat (480) tick();
    m_low = 1'b0;
    n_wait = 0;
    while (!o_owr && n_wait < 100) begin
      tick();
      n_wait++;
    end
    chk("arst_pres_seen", 32'(o_owr), 32'd1);
    repeat (10) tick();
    rst_n = 1'b0;
    #1;
    chk("arst_owr", 32'(o_owr), 32'd0);
    chk("arst_cmd", 32'(o_cmd), 32'd0);
    tick();
    rst_n = 1'b1;
    repeat (3) tick();
    read_scratch_chk(16'h0550, "arst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
